// File: rtl/shader_tcache_fill.sv
// shader_tcache_fill: unpacks a 32-bit memory stream into 4-bit texels,
// assembles them into a full-width masked line buffer, then runs the
// texture cache strobe/DMA commit sequence so the line lands in one write.
module shader_tcache_fill #(
  parameter int TCACHE_SIZE = 3
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       start,
  input  logic [2*TCACHE_SIZE-1:0]   load_base,
  input  logic [2*TCACHE_SIZE:0]     load_count,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [31:0]                s_data,
  input  logic                       cache_idle,
  output logic                       strobe,
  output logic                       dma_en,
  output logic [3:0]                 dma_data [2**(2*TCACHE_SIZE)],
  output logic [2**(2*TCACHE_SIZE)-1:0] dma_mask,
  output logic                       busy,
  output logic                       done
);

  localparam int TEXELS = 2**(2*TCACHE_SIZE);
  localparam int IDX_W  = 2*TCACHE_SIZE;
  localparam int CNT_W  = 2*TCACHE_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    ARM    = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  texel_cnt_q, texel_cnt_d;
  logic [TEXELS-1:0] mask_q, mask_d;
  logic [3:0]        data_q [TEXELS];
  logic [3:0]        data_d [TEXELS];
  logic              strobe_q, strobe_d;
  logic              dma_en_q, dma_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IDX_W-1:0]  wr_idx [8];
  logic              wr_en  [8];

  // Per-nibble target index (wrapping modulo line size) and whether the nibble is still within the requested count
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      wr_idx[k] = base_q + texel_cnt_q[IDX_W-1:0] + IDX_W'(k);
      wr_en[k]  = (texel_cnt_q + CNT_W'(k)) < count_q;
    end
  end

  // Next-state, line-buffer assembly and registered-output decode
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    base_d      = base_q;
    count_d     = count_q;
    texel_cnt_d = texel_cnt_q;
    mask_d      = mask_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = load_base;
          texel_cnt_d = '0;
          mask_d      = '0;
          if (load_count == '0) begin
            count_d = '0;
            state_d = DONE;
          end else if (load_count > CNT_W'(TEXELS)) begin
            count_d = CNT_W'(TEXELS);
            state_d = FILL;
          end else begin
            count_d = load_count;
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (s_valid) begin
          for (int k = 0; k < 8; k++) begin
            if (wr_en[k]) begin
              data_d[wr_idx[k]] = s_data[4*k +: 4];
              mask_d[wr_idx[k]] = 1'b1;
            end
          end
          if ((count_q - texel_cnt_q) <= CNT_W'(8)) begin
            texel_cnt_d = count_q;
            state_d     = ARM;
          end else begin
            texel_cnt_d = texel_cnt_q + CNT_W'(8);
          end
        end
      end

      ARM: begin
        if (cache_idle) begin
          phase_d = 2'd0;
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        if (phase_q == 2'd3) begin
          state_d = DONE;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end

      DONE: begin
        mask_d  = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    strobe_d = (state_d == COMMIT) && (phase_d == 2'd0);
    dma_en_d = (state_d == COMMIT);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  // State, line buffer and output registers with asynchronous active-low reset
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      base_q      <= '0;
      count_q     <= '0;
      texel_cnt_q <= '0;
      mask_q      <= '0;
      for (int i = 0; i < TEXELS; i++) begin
        data_q[i] <= 4'h0;
      end
      strobe_q    <= 1'b0;
      dma_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      base_q      <= base_d;
      count_q     <= count_d;
      texel_cnt_q <= texel_cnt_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      dma_en_q    <= dma_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_ready  = (state_q == FILL);
  assign strobe   = strobe_q;
  assign dma_en   = dma_en_q;
  assign dma_data = data_q;
  assign dma_mask = mask_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shader_tcache_fill.sv
// Self-checking bench for shader_tcache_fill: directed scenarios plus random
// loads, compared against a texel-image / cycle-schedule reference model.
module tb_shader_tcache_fill;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic [5:0]  load_base;
  logic [6:0]  load_count;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        cache_idle;
  logic        strobe;
  logic        dma_en;
  logic [3:0]  dma_data [64];
  logic [63:0] dma_mask;
  logic        busy;
  logic        done;

  int testsRun;
  int testsFailed;

  // Reference image of what the cache line buffer should hold
  logic [3:0] modelData [64];

  shader_tcache_fill #(.TCACHE_SIZE(3)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .load_base  (load_base),
    .load_count (load_count),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cache_idle (cache_idle),
    .strobe     (strobe),
    .dma_en     (dma_en),
    .dma_data   (dma_data),
    .dma_mask   (dma_mask),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock, period 10
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flatten the DUT texel array for whole-line comparisons
  function automatic logic [255:0] packDut();
    logic [255:0] r;
    for (int i = 0; i < 64; i++) r[4*i +: 4] = dma_data[i];
    return r;
  endfunction

  // Flatten the reference texel image
  function automatic logic [255:0] packModel();
    logic [255:0] r;
    for (int i = 0; i < 64; i++) r[4*i +: 4] = modelData[i];
    return r;
  endfunction

  // Every output must sit at its reset value
  task automatic checkReset(input string tag);
    checkOutput({tag, "_s_ready"}, s_ready, 1'b0);
    checkOutput({tag, "_strobe"}, strobe, 1'b0);
    checkOutput({tag, "_dma_en"}, dma_en, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_mask"}, dma_mask, 64'h0);
    checkOutput({tag, "_data"}, packDut(), 256'h0);
  endtask

  // Runs one load and checks every cycle against the schedule predicted from
  // word acceptances and cache_idle: ARM after the last word, C0 one cycle
  // after the first idle cycle in ARM, done four cycles after C0.
  task automatic applyStimulus(input int base, input int count, input bit useFixed,
                               input logic [31:0] fixedWord, input int fixedGap,
                               input int maxGap, input int idleDelay,
                               input bit pulseStart, input int resetCycle);
    int cc, wordsTotal, acc, gapLeft, armStart, c0, doneCycle, c, idx;
    bit didReset;
    logic [31:0] words [8];
    logic [63:0] expMask;
    logic [255:0] expData;

    cc = (count > 64) ? 64 : count;
    wordsTotal = (cc + 7) / 8;
    for (int j = 0; j < 8; j++) words[j] = useFixed ? fixedWord : $urandom();

    expMask = '0;
    for (int n = 0; n < cc; n++) begin
      idx = (base + n) % 64;
      modelData[idx] = words[n / 8][4*(n % 8) +: 4];
      expMask[idx] = 1'b1;
    end
    expData = packModel();

    @(negedge aclk);
    start      = 1'b1;
    load_base  = 6'(base);
    load_count = 7'(count);
    s_valid    = 1'b0;
    cache_idle = (idleDelay == 0);

    acc       = 0;
    armStart  = -1;
    c0        = -1;
    doneCycle = (cc == 0) ? 1 : -1;
    gapLeft   = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
    didReset  = 1'b0;
    c         = 0;

    while (1) begin
      @(negedge aclk);
      c++;
      if (c > 3000) begin
        checkOutput("timeout", 1'b1, 1'b0);
        break;
      end
      if (c0 >= 0 && doneCycle < 0) doneCycle = c0 + 4;

      checkOutput("s_ready", s_ready, acc < wordsTotal);
      checkOutput("strobe", strobe, c == c0);
      checkOutput("dma_en", dma_en, (c0 >= 0) && (c >= c0) && (c <= c0 + 3));
      checkOutput("done", done, c == doneCycle);
      checkOutput("busy", busy, (doneCycle < 0) || (c <= doneCycle));
      if (c == c0) begin
        checkOutput("commit_mask", dma_mask, expMask);
        checkOutput("commit_data", packDut(), expData);
        checkOutput("strobe_idle", cache_idle, 1'b1);
      end
      if (doneCycle > 0 && c == doneCycle + 1) begin
        checkOutput("mask_cleared", dma_mask, 64'h0);
        start = 1'b0;
        s_valid = 1'b0;
        break;
      end

      start = 1'b0;
      if (pulseStart && (c == 2 || (c0 >= 0 && c == c0 + 1))) begin
        start      = 1'b1;
        load_base  = 6'($urandom());
        load_count = 7'($urandom());
      end

      if (acc < wordsTotal) begin
        if (gapLeft > 0) begin
          s_valid = 1'b0;
          s_data  = $urandom();
          gapLeft--;
        end else begin
          s_valid = 1'b1;
          s_data  = words[acc];
          acc++;
          if (acc == wordsTotal) armStart = c + 1;
          else if (acc == 1 && fixedGap > 0) gapLeft = fixedGap;
          else gapLeft = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
        end
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = $urandom();
      end

      if (idleDelay == 0) cache_idle = 1'b1;
      else if (armStart < 0 || c < armStart) cache_idle = 1'b0;
      else cache_idle = (c >= armStart + idleDelay);

      if (armStart >= 0 && c >= armStart && cache_idle && c0 < 0) c0 = c + 1;

      if (resetCycle > 0 && c == resetCycle) begin
        #2 aresetn = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) modelData[i] = 4'h0;
        checkReset("async_rst");
        didReset = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        break;
      end
    end

    if (didReset) begin
      repeat (2) begin
        @(negedge aclk);
        checkOutput("done_in_reset", done, 1'b0);
        checkOutput("busy_in_reset", busy, 1'b0);
      end
      aresetn = 1'b1;
    end
  endtask

  // Directed scenarios followed by randomized loads
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    aresetn     = 1'b0;
    start       = 1'b0;
    load_base   = '0;
    load_count  = '0;
    s_valid     = 1'b0;
    s_data      = '0;
    cache_idle  = 1'b1;
    for (int i = 0; i < 64; i++) modelData[i] = 4'h0;

    repeat (2) @(negedge aclk);
    checkReset("reset");
    aresetn = 1'b1;

    // Full line, back-to-back: strobe at 10, dma_en 10..13, done at 14
    applyStimulus(0, 64, 1'b1, 32'h76543210, 0, 0, 0, 1'b0, 0);
    // Partial load wrapping past the end of the line
    applyStimulus(62, 4, 1'b1, 32'hFEDCBA98, 0, 0, 0, 1'b0, 0);
    checkOutput("wrap_t62", modelData[62], 4'h8);
    checkOutput("wrap_t1", modelData[1], 4'hB);
    // Back-pressure gap of 5 between words and cache busy for 7 cycles in ARM
    applyStimulus(10, 16, 1'b0, 32'h0, 5, 0, 7, 1'b0, 0);
    // Zero count then oversize count
    applyStimulus(5, 0, 1'b0, 32'h0, 0, 0, 0, 1'b0, 0);
    applyStimulus(33, 100, 1'b0, 32'h0, 0, 0, 0, 1'b0, 0);
    // Start pulses while busy are ignored
    applyStimulus(20, 64, 1'b0, 32'h0, 0, 1, 2, 1'b1, 0);
    // Reset after three words, then reset in C2
    applyStimulus(0, 64, 1'b0, 32'h0, 0, 0, 0, 1'b0, 4);
    applyStimulus(17, 8, 1'b0, 32'h0, 0, 0, 0, 1'b0, 5);
    // A normal load after the resets
    applyStimulus(40, 30, 1'b0, 32'h0, 0, 0, 1, 1'b0, 0);

    for (int t = 0; t < 12; t++) begin
      int sel, cnt;
      sel = $urandom_range(0, 9);
      if (sel == 0) cnt = 0;
      else if (sel == 1) cnt = $urandom_range(65, 127);
      else cnt = $urandom_range(1, 64);
      applyStimulus($urandom_range(0, 63), cnt, 1'b0, 32'h0, 0,
                    $urandom_range(0, 3), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
